// File: rtl/memory_stage_if.sv
// Execute-to-memory bus for memory_stage: op, operands and PC in;
// MEM/WB registered fields, popped PC and upstream stall out.
interface memory_stage_if;
  logic [2:0]  MemOp;
  logic [15:0] ALUResult;
  logic [15:0] ALUfirstOperand;
  logic [31:0] PCIn;
  logic        RegWriteIn;
  logic [2:0]  DstAddrIn;
  logic        MemToRegIn;
  logic        flush;
  logic        stall;
  logic [15:0] MemResult;
  logic [15:0] ALUResultOut;
  logic        RegWriteOut;
  logic [2:0]  DstAddrOut;
  logic        MemToRegOut;
  logic [31:0] PCOut;
  logic        PCValid;

  modport master (
    output MemOp, ALUResult, ALUfirstOperand, PCIn,
    output RegWriteIn, DstAddrIn, MemToRegIn, flush,
    input  stall, MemResult, ALUResultOut, RegWriteOut,
    input  DstAddrOut, MemToRegOut, PCOut, PCValid
  );

  modport slave (
    input  MemOp, ALUResult, ALUfirstOperand, PCIn,
    input  RegWriteIn, DstAddrIn, MemToRegIn, flush,
    output stall, MemResult, ALUResultOut, RegWriteOut,
    output DstAddrOut, MemToRegOut, PCOut, PCValid
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: data load/store, 16-bit stack push/pop, 32-bit PC push/pop.
// Ports: clk, rst (sync, active high), bus (memory_stage_if.slave).
module memory_stage #(
  parameter int AW = 11,
  parameter logic [AW-1:0] SP_RESET = {AW{1'b1}}
) (
  input logic clk,
  input logic rst,
  memory_stage_if.slave bus
);

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_STORE  = 3'b010;
  localparam logic [2:0] OP_PUSH   = 3'b011;
  localparam logic [2:0] OP_POP    = 3'b100;
  localparam logic [2:0] OP_PUSHPC = 3'b101;
  localparam logic [2:0] OP_POPPC  = 3'b110;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PUSH2 = 2'd1;
  localparam logic [1:0] POP2  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] sp;
  logic [AW-1:0] spInc;
  logic [AW-1:0] spDec;
  logic [15:0]   pcLow;

  logic [15:0]   mem [0:(1<<AW)-1];

  logic [15:0]   capAlu;
  logic          capRegWrite;
  logic [2:0]    capDst;
  logic          capMemToReg;

  logic          isIdle;
  logic [2:0]    op;
  logic          memWe;
  logic [AW-1:0] wrAddr;
  logic [AW-1:0] rdAddr;
  logic [15:0]   wrData;
  logic [15:0]   rdData;

  assign spInc  = sp + 1'b1;
  assign spDec  = sp - 1'b1;
  assign isIdle = (state == IDLE);

  // Flushed or mid-sequence inputs decode as no-op.
  assign op = (isIdle && !bus.flush) ? bus.MemOp : OP_NONE;

  assign bus.stall = !rst &&
    (op == OP_PUSHPC || op == OP_POPPC);

  always_comb begin
    memWe  = 1'b0;
    wrAddr = sp;
    wrData = bus.ALUfirstOperand;
    rdAddr = spInc;
    unique case (1'b1)
      state == PUSH2: begin
        memWe  = 1'b1;
        wrData = pcLow;
      end
      state == POP2: ;
      op == OP_LOAD:
        rdAddr = bus.ALUResult[AW-1:0];
      op == OP_STORE: begin
        memWe  = 1'b1;
        wrAddr = bus.ALUResult[AW-1:0];
      end
      op == OP_PUSH:
        memWe = 1'b1;
      op == OP_PUSHPC: begin
        memWe  = 1'b1;
        wrData = bus.PCIn[31:16];
      end
      default: ;
    endcase
  end

  assign rdData = mem[rdAddr];

  // No reset on the array; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (memWe && !rst)
      mem[wrAddr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sp               <= SP_RESET;
      pcLow            <= '0;
      capAlu           <= '0;
      capRegWrite      <= 1'b0;
      capDst           <= '0;
      capMemToReg      <= 1'b0;
      bus.MemResult    <= '0;
      bus.ALUResultOut <= '0;
      bus.RegWriteOut  <= 1'b0;
      bus.DstAddrOut   <= '0;
      bus.MemToRegOut  <= 1'b0;
      bus.PCOut        <= '0;
      bus.PCValid      <= 1'b0;
    end else begin
      state         <= IDLE;
      bus.PCValid   <= 1'b0;
      bus.MemResult <= '0;
      if (state == PUSH2 || state == POP2) begin
        // Second half: retire the fields captured in the first half.
        bus.ALUResultOut <= capAlu;
        bus.RegWriteOut  <= capRegWrite;
        bus.DstAddrOut   <= capDst;
        bus.MemToRegOut  <= capMemToReg;
        if (state == PUSH2) begin
          sp <= spDec;
        end else begin
          sp          <= spInc;
          bus.PCOut   <= {rdData, pcLow};
          bus.PCValid <= 1'b1;
        end
      end else begin
        bus.ALUResultOut <= bus.ALUResult;
        bus.RegWriteOut  <= bus.RegWriteIn && !bus.flush;
        bus.DstAddrOut   <= bus.DstAddrIn;
        bus.MemToRegOut  <= bus.MemToRegIn;
        case (op)
          OP_LOAD:
            bus.MemResult <= rdData;
          OP_PUSH:
            sp <= spDec;
          OP_POP: begin
            bus.MemResult <= rdData;
            sp            <= spInc;
          end
          OP_PUSHPC: begin
            sp              <= spDec;
            pcLow           <= bus.PCIn[15:0];
            state           <= PUSH2;
            capAlu          <= bus.ALUResult;
            capRegWrite     <= bus.RegWriteIn;
            capDst          <= bus.DstAddrIn;
            capMemToReg     <= bus.MemToRegIn;
            bus.RegWriteOut <= 1'b0;
          end
          OP_POPPC: begin
            sp              <= spInc;
            pcLow           <= rdData;
            state           <= POP2;
            capAlu          <= bus.ALUResult;
            capRegWrite     <= bus.RegWriteIn;
            capDst          <= bus.DstAddrIn;
            capMemToReg     <= bus.MemToRegIn;
            bus.RegWriteOut <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed table, hand sequences for the
// two-cycle/reset/wrap cases, and randomized ops against a stack model.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(.AW(11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] alu,
                       input logic [15:0] first, input logic [31:0] pc,
                       input logic rw, input logic [2:0] dst,
                       input logic m2r, input logic fl);
    bus.MemOp           = op;
    bus.ALUResult       = alu;
    bus.ALUfirstOperand = first;
    bus.PCIn            = pc;
    bus.RegWriteIn      = rw;
    bus.DstAddrIn       = dst;
    bus.MemToRegIn      = m2r;
    bus.flush           = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [2:0] op, input logic [15:0] alu,
                     input logic [15:0] first);
    drive(op, alu, first, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] alu;
    logic [15:0] first;
    logic        rw;
    logic [2:0]  dst;
    logic        fl;
    logic [15:0] expMem;
    logic        expRw;
  } vec_t;

  vec_t vt[$];

  logic [15:0] mMem [0:2047];
  int          mSp;
  logic [31:0] mPc;

  initial begin
    rst = 1'b1;
    drive(3'b101, 16'h0, 16'h0, 32'h1234_5678, 1'b1, 3'd7, 1'b1, 1'b0);
    #1;
    chk("stall_in_reset", bus.stall, 1'b0);
    tick();
    tick();
    chk("rst_MemResult", bus.MemResult, 16'h0);
    chk("rst_RegWrite", bus.RegWriteOut, 1'b0);
    chk("rst_PCValid", bus.PCValid, 1'b0);
    chk("rst_PCOut", bus.PCOut, 32'h0);
    chk("rst_AluOut", bus.ALUResultOut, 16'h0);
    rst = 1'b0;
    drive(3'b000, 16'h0, 16'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

    vt.push_back(vec_t'{3'b010, 16'h0012, 16'hBEEF, 1'b0, 3'd1, 1'b0, 16'h0000, 1'b0});
    vt.push_back(vec_t'{3'b001, 16'h0012, 16'h0000, 1'b1, 3'd3, 1'b0, 16'hBEEF, 1'b1});
    vt.push_back(vec_t'{3'b001, 16'hF812, 16'h0000, 1'b1, 3'd4, 1'b0, 16'hBEEF, 1'b1});
    vt.push_back(vec_t'{3'b011, 16'h0000, 16'h1111, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0});
    vt.push_back(vec_t'{3'b011, 16'h0001, 16'h2222, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0});
    vt.push_back(vec_t'{3'b100, 16'h0002, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h2222, 1'b1});
    vt.push_back(vec_t'{3'b100, 16'h0003, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h1111, 1'b1});
    vt.push_back(vec_t'{3'b001, 16'h07FF, 16'h0000, 1'b1, 3'd6, 1'b0, 16'h1111, 1'b1});
    vt.push_back(vec_t'{3'b010, 16'h0012, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h0000, 1'b0});
    vt.push_back(vec_t'{3'b001, 16'h0012, 16'h0000, 1'b1, 3'd7, 1'b0, 16'hBEEF, 1'b1});
    vt.push_back(vec_t'{3'b000, 16'hA5A5, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h0000, 1'b1});
    vt.push_back(vec_t'{3'b111, 16'h5A5A, 16'h0000, 1'b0, 3'd2, 1'b0, 16'h0000, 1'b0});

    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].alu, vt[i].first, 32'h0,
            vt[i].rw, vt[i].dst, 1'b0, vt[i].fl);
      #1;
      chk($sformatf("vec%0d_stall", i), bus.stall, 1'b0);
      tick();
      chk($sformatf("vec%0d_MemResult", i), bus.MemResult, vt[i].expMem);
      chk($sformatf("vec%0d_RegWrite", i), bus.RegWriteOut, vt[i].expRw);
      chk($sformatf("vec%0d_AluOut", i), bus.ALUResultOut, vt[i].alu);
      chk($sformatf("vec%0d_Dst", i), bus.DstAddrOut, vt[i].dst);
    end

    // Push PC, flush during second half, then pop PC.
    drive(3'b101, 16'h1234, 16'h0, 32'h0001_ABCD, 1'b1, 3'd6, 1'b1, 1'b0);
    #1;
    chk("pushpc_stall1", bus.stall, 1'b1);
    tick();
    chk("pushpc_bubble_rw", bus.RegWriteOut, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("pushpc_stall2", bus.stall, 1'b0);
    tick();
    chk("pushpc_rw", bus.RegWriteOut, 1'b1);
    chk("pushpc_dst", bus.DstAddrOut, 3'd6);
    chk("pushpc_alu", bus.ALUResultOut, 16'h1234);
    chk("pushpc_m2r", bus.MemToRegOut, 1'b1);
    op1(3'b001, 16'h07FF, 16'h0);
    chk("pushpc_hi", bus.MemResult, 16'h0001);
    op1(3'b001, 16'h07FE, 16'h0);
    chk("pushpc_lo", bus.MemResult, 16'hABCD);
    op1(3'b011, 16'h0, 16'h7777);
    op1(3'b001, 16'h07FD, 16'h0);
    chk("pushpc_sp7FD", bus.MemResult, 16'h7777);
    op1(3'b100, 16'h0, 16'h0);
    chk("pushpc_pop7777", bus.MemResult, 16'h7777);

    drive(3'b110, 16'h0, 16'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    chk("poppc_stall1", bus.stall, 1'b1);
    tick();
    chk("poppc_valid1", bus.PCValid, 1'b0);
    #1;
    chk("poppc_stall2", bus.stall, 1'b0);
    tick();
    chk("poppc_valid2", bus.PCValid, 1'b1);
    chk("poppc_pc", bus.PCOut, 32'h0001_ABCD);
    op1(3'b000, 16'h0, 16'h0);
    chk("poppc_valid3", bus.PCValid, 1'b0);
    chk("poppc_pchold", bus.PCOut, 32'h0001_ABCD);
    op1(3'b011, 16'h0, 16'h3333);
    op1(3'b001, 16'h07FF, 16'h0);
    chk("poppc_sp7FF", bus.MemResult, 16'h3333);
    op1(3'b100, 16'h0, 16'h0);

    // Reset in the middle of a pop PC.
    op1(3'b101, 16'h0, 16'h0);
    bus.PCIn = 32'hDEAD_BEEF;
    tick();
    op1(3'b110, 16'h0, 16'h0);
    rst = 1'b1;
    drive(3'b000, 16'h0, 16'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    chk("rstpop_stall", bus.stall, 1'b0);
    tick();
    rst = 1'b0;
    chk("rstpop_valid", bus.PCValid, 1'b0);
    chk("rstpop_pc", bus.PCOut, 32'h0);
    chk("rstpop_mem", bus.MemResult, 16'h0);
    chk("rstpop_rw", bus.RegWriteOut, 1'b0);
    op1(3'b000, 16'h0, 16'h0);
    chk("rstpop_nopulse", bus.PCValid, 1'b0);
    op1(3'b011, 16'h0, 16'h4444);
    op1(3'b001, 16'h07FF, 16'h0);
    chk("rstpop_sp7FF", bus.MemResult, 16'h4444);
    op1(3'b100, 16'h0, 16'h0);

    // Stack wrap in both directions.
    op1(3'b010, 16'h0000, 16'h5A5A);
    op1(3'b100, 16'h0, 16'h0);
    chk("wrap_pop", bus.MemResult, 16'h5A5A);
    op1(3'b011, 16'h0, 16'h6B6B);
    op1(3'b001, 16'h0000, 16'h0);
    chk("wrap_push_mem0", bus.MemResult, 16'h6B6B);
    op1(3'b011, 16'h0, 16'h1010);
    op1(3'b001, 16'h07FF, 16'h0);
    chk("wrap_sp7FF", bus.MemResult, 16'h1010);

    // Randomized phase against a transaction-level stack model.
    rst = 1'b1;
    op1(3'b000, 16'h0, 16'h0);
    rst = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      mMem[a] = 16'(a * 16'h9E37) ^ 16'h5A3C;
      op1(3'b010, 16'(a), mMem[a]);
    end
    mSp = 2047;
    mPc = 32'h0;

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  op;
      logic [2:0]  eff;
      logic [15:0] alu;
      logic [15:0] first;
      logic [31:0] pc;
      logic        rw;
      logic [2:0]  dst;
      logic        m2r;
      logic        fl;
      logic [15:0] expMem;
      logic [15:0] lo;
      logic [15:0] hi;
      op    = 3'($urandom_range(0, 7));
      fl    = ($urandom_range(0, 7) == 0);
      alu   = 16'($urandom);
      first = 16'($urandom);
      pc    = $urandom;
      rw    = 1'($urandom_range(0, 1));
      dst   = 3'($urandom_range(0, 7));
      m2r   = 1'($urandom_range(0, 1));
      eff   = fl ? 3'b000 : op;
      drive(op, alu, first, pc, rw, dst, m2r, fl);
      #1;
      chk("rnd_stall", bus.stall, (eff == 3'b101 || eff == 3'b110));
      if (eff == 3'b101 || eff == 3'b110) begin
        tick();
        chk("rnd_bubble_rw", bus.RegWriteOut, 1'b0);
        chk("rnd_bubble_valid", bus.PCValid, 1'b0);
        drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              $urandom, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
        #1;
        chk("rnd_stall2", bus.stall, 1'b0);
        tick();
        if (eff == 3'b101) begin
          mMem[mSp] = pc[31:16];
          mSp = (mSp - 1) & 2047;
          mMem[mSp] = pc[15:0];
          mSp = (mSp - 1) & 2047;
        end else begin
          mSp = (mSp + 1) & 2047;
          lo = mMem[mSp];
          mSp = (mSp + 1) & 2047;
          hi = mMem[mSp];
          mPc = {hi, lo};
        end
        chk("rnd2_rw", bus.RegWriteOut, rw);
        chk("rnd2_dst", bus.DstAddrOut, dst);
        chk("rnd2_m2r", bus.MemToRegOut, m2r);
        chk("rnd2_alu", bus.ALUResultOut, alu);
        chk("rnd2_valid", bus.PCValid, (eff == 3'b110));
        chk("rnd2_pc", bus.PCOut, mPc);
      end else begin
        expMem = 16'h0;
        case (eff)
          3'b001: expMem = mMem[alu[10:0]];
          3'b010: mMem[alu[10:0]] = first;
          3'b011: begin
            mMem[mSp] = first;
            mSp = (mSp - 1) & 2047;
          end
          3'b100: begin
            mSp = (mSp + 1) & 2047;
            expMem = mMem[mSp];
          end
          default: ;
        endcase
        tick();
        chk("rnd_mem", bus.MemResult, expMem);
        chk("rnd_rw", bus.RegWriteOut, rw && !fl);
        chk("rnd_dst", bus.DstAddrOut, dst);
        chk("rnd_m2r", bus.MemToRegOut, m2r);
        chk("rnd_alu", bus.ALUResultOut, alu);
        chk("rnd_valid", bus.PCValid, 1'b0);
        chk("rnd_pc", bus.PCOut, mPc);
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the 16-bit ALU result and the forwarded first operand.
- Performs data-memory load/store, 16-bit stack push/pop, and 32-bit PC push/pop (CALL/INT/RET/RTI).
- Owns the stack pointer and an internal data memory.
- Registers everything into the MEM/WB boundary and raises a stall toward upstream stages during the two-cycle PC operations.

Parameters:
- AW, 11, data-memory address width; depth = 2^AW 16-bit words.
- SP_RESET, 2^AW-1, stack pointer value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- MemOp  in  3  000 none, 001 load, 010 store, 011 push, 100 pop, 101 push PC, 110 pop PC, 111 none
- ALUResult  in  16  address for load/store; writeback value otherwise
- ALUfirstOperand  in  16  store/push data
- PCIn  in  32  PC to push for op 101
- RegWriteIn  in  1  writeback enable, passed through
- DstAddrIn  in  3  destination register, passed through
- MemToRegIn  in  1  selects memory data at writeback, passed through
- flush  in  1  turn the current input into a bubble
- stall  out  1  upstream must hold its inputs this cycle
- MemResult  out  16  registered memory read data
- ALUResultOut  out  16  registered ALUResult
- RegWriteOut  out  1  registered
- DstAddrOut  out  3  registered
- MemToRegOut  out  1  registered
- PCOut  out  32  popped PC
- PCValid  out  1  one-cycle pulse when PCOut is valid

Behaviour:
- Reset (rst=1 at clk edge):
  - all outputs 0
  - SP <= SP_RESET
  - FSM -> IDLE
  - latched PC cleared
  - memory contents untouched
  - an in-progress two-cycle op is abandoned (no further write, no PCValid).
- Addressing: load/store use ALUResult[AW-1:0]; upper bits are ignored. SP is AW bits wide and wraps modulo 2^AW in both directions.
- Latency: one cycle. Outputs reflect the op sampled at the previous edge. Memory is read combinationally and captured into MemResult at the edge.
- Single-cycle ops, all in IDLE:
  - Load: MemResult <= mem[addr].
  - Store: mem[addr] <= ALUfirstOperand; MemResult <= 0.
  - Push: mem[SP] <= ALUfirstOperand; SP <= SP-1 (post-decrement).
  - Pop: MemResult <= mem[SP+1]; SP <= SP+1 (pre-increment).
  - None: no memory or SP change; MemResult <= 0.
- FSM states: IDLE, PUSH2, POP2.
  - IDLE, MemOp=101 (push PC):
    - stall=1 (combinational)
    - mem[SP] <= PCIn[31:16]; SP <= SP-1
    - latch PCIn[15:0]
    - -> PUSH2
  - PUSH2:
    - stall=0
    - mem[SP] <= latched low word; SP <= SP-1
    - -> IDLE
    - MemOp/PCIn inputs ignored this cycle.
  - IDLE, MemOp=110 (pop PC):
    - stall=1
    - low <= mem[SP+1]; SP <= SP+1
    - -> POP2
  - POP2:
    - stall=0
    - PCOut <= {mem[SP+1], low}; SP <= SP+1; PCValid <= 1 for one cycle
    - -> IDLE
- Pass-through fields:
  - Captured on the first cycle of a two-cycle op.
  - During the second cycle, RegWriteOut is forced to 0, so the bubble writes nothing.
  - The captured fields are presented on the cycle after PUSH2/POP2.
- PCValid is 0 on every other cycle. PCOut holds its last value.
- Flush:
  - When flush=1 in IDLE, the input is treated as MemOp=none and RegWriteIn=0. No memory write, no SP change.
  - Flush is ignored in PUSH2/POP2: two-cycle ops complete atomically.
- stall is asserted only in the first cycle of ops 101/110. It is never asserted in PUSH2/POP2 or during reset.
- Pop at SP=2^AW-1 reads mem[0], and SP wraps to 0. Push at SP=0 writes mem[0], and SP wraps to 2^AW-1. No error is flagged.

Test Plan:
- Reset, then store ALUfirstOperand=0xBEEF at ALUResult=0x0012, then load 0x0012 -> next-cycle MemResult=0xBEEF; a load of 0xF812 (AW=11) also returns 0xBEEF.
- Push 0x1111, push 0x2222, pop, pop -> MemResult 0x2222 then 0x1111; SP back to 0x7FF; mem[0x7FF]=0x1111.
- Push PC 0x0001_ABCD:
  - stall=1 for exactly one cycle
  - mem[0x7FF]=0x0001, mem[0x7FE]=0xABCD, SP=0x7FD
  - then pop PC -> stall one cycle, PCValid pulses once with PCOut=0x0001ABCD, SP=0x7FF.
- Flush with MemOp=store and RegWriteIn=1 -> memory unchanged, RegWriteOut=0. Flush asserted during PUSH2 -> low word still written.
- rst asserted in POP2 -> next cycle PCValid=0, SP=0x7FF, stall=0, all outputs 0.
- Pop with SP=0x7FF after writing mem[0]=0x5A5A -> MemResult=0x5A5A, SP=0x000. A following push writes mem[0] and SP wraps to 0x7FF.
